// File: rtl/timer_counter.sv
// timer_counter: 32-bit down-counting timer with a three-word register file
// (CTRL, PRESET, COUNT), one-shot and auto-reload modes, and a maskable
// level interrupt intended for one HWInt bit of the coprocessor.
//
// Register map (addr):
//   0 CTRL   [0] EN, [2:1] MODE (01 auto-reload, anything else one-shot),
//            [3] IM (irq mask), [31:4] read as zero
//   1 PRESET 32-bit read/write reload value
//   2 COUNT  32-bit read-only current count
//   3 reserved, reads zero, writes ignored
//
// Sequencing: IDLE -> LOAD -> CNT -> INT. A write to CTRL or PRESET always
// wins over the counter sequencer in the same cycle: the sequencer does not
// advance on such a cycle. A PRESET write sends the sequencer to IDLE, and a
// CTRL write that clears EN does the same; a CTRL write that keeps EN set
// leaves the sequencer where it is for that cycle. Writes to COUNT or to the
// reserved word have no effect at all and the sequencer advances normally.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    // Word selects as decoded by the upstream bridge
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // MODE encoding that selects auto-reload; every other code is one-shot
    localparam logic [1:0] MODE_AUTO   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Architectural state
    state_t      state_r;
    logic        en_r;
    logic [1:0]  mode_r;
    logic        im_r;
    logic [31:0] preset_r;
    logic [31:0] count_r;
    logic        irq_flag_r;

    // Decoded write strobes and mode qualifier
    logic        ctrl_wr_s;
    logic        preset_wr_s;
    logic        auto_reload_s;
    logic        count_zero_s;

    // Decode which register (if any) the current bus cycle writes
    always_comb begin
        ctrl_wr_s     = 1'b0;
        preset_wr_s   = 1'b0;
        auto_reload_s = (mode_r == MODE_AUTO);
        count_zero_s  = (count_r == 32'd0);
        if (we) begin
            ctrl_wr_s   = (addr == ADDR_CTRL);
            preset_wr_s = (addr == ADDR_PRESET);
        end else begin
            ctrl_wr_s   = 1'b0;
            preset_wr_s = 1'b0;
        end
    end

    // Register file and counter sequencer; bus writes take priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            en_r       <= 1'b0;
            mode_r     <= 2'b00;
            im_r       <= 1'b0;
            preset_r   <= 32'd0;
            count_r    <= 32'd0;
            irq_flag_r <= 1'b0;
        end else if (preset_wr_s) begin
            // New reload value: drop any pending flag and restart via LOAD
            preset_r   <= din;
            irq_flag_r <= 1'b0;
            state_r    <= ST_IDLE;
        end else if (ctrl_wr_s) begin
            en_r       <= din[0];
            mode_r     <= din[2:1];
            im_r       <= din[3];
            irq_flag_r <= 1'b0;
            if (!din[0]) begin
                // Disabling stops the count immediately, COUNT keeps its value
                state_r <= ST_IDLE;
            end else begin
                state_r <= state_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en_r) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    count_r <= preset_r;
                    state_r <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en_r) begin
                        state_r <= ST_IDLE;
                    end else if (count_zero_s) begin
                        // Expiry: the flag rises as INT is entered
                        state_r    <= ST_INT;
                        irq_flag_r <= 1'b1;
                    end else begin
                        count_r <= count_r - 32'd1;
                    end
                end
                ST_INT: begin
                    if (auto_reload_s) begin
                        // Periodic mode: one-cycle flag pulse, then reload
                        state_r    <= ST_LOAD;
                        irq_flag_r <= 1'b0;
                    end else begin
                        // One-shot: stop and keep the flag until software acks
                        en_r    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read mux for the word selected by addr
    always_comb begin
        dout = 32'd0;
        case (addr)
            ADDR_CTRL:   dout = {28'd0, im_r, mode_r, en_r};
            ADDR_PRESET: dout = preset_r;
            ADDR_COUNT:  dout = count_r;
            default:     dout = 32'd0;
        endcase
    end

    // Interrupt is a pure function of stored state, never of the bus inputs
    assign irq = irq_flag_r & im_r;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// bus traffic, all compared against a timeline-based reference model.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] obs [4];
    logic        obs_irq;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a run is a timeline of elapsed steps e since the
    // sequence (re)started. e=0 is the reload step, e=1..N+1 show
    // COUNT = N-(e-1), e=N+2 is expiry. Bus writes pre-empt the timeline.
    logic        m_en, m_im, m_flag, m_run;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    longint      m_e;

    function automatic void model_reset();
        m_en = 1'b0; m_im = 1'b0; m_flag = 1'b0; m_run = 1'b0;
        m_mode = 2'b00; m_preset = 32'd0; m_count = 32'd0; m_e = 0;
    endfunction

    function automatic void model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
        longint n;
        n = longint'({32'd0, m_preset});
        if (w && a == 2'd1) begin
            m_preset = d; m_flag = 1'b0; m_run = 1'b0;
        end else if (w && a == 2'd0) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 1'b0;
            if (!d[0]) m_run = 1'b0;
        end else if (!m_run) begin
            if (m_en) begin
                m_run = 1'b1; m_e = 0;
            end
        end else if (m_e == n + 2) begin
            if (m_mode == 2'b01) begin
                m_e = 0; m_flag = 1'b0;
            end else begin
                m_en = 1'b0; m_run = 1'b0;
            end
        end else begin
            m_e = m_e + 1;
            if (m_e <= n + 1) m_count = 32'(n - (m_e - 1));
            else m_flag = 1'b1;
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Read every word and irq, comparing against the model
    task automatic read_all();
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            obs[a] = dout;
            chk_eq($sformatf("rd%0d", a), dout, exp_read(2'(a)));
        end
        obs_irq = irq;
        chk_eq("irq", {31'd0, irq}, {31'd0, m_flag & m_im});
    endtask

    // One bus cycle: drive, take the edge, then sample away from the edge
    task automatic cycle(input logic w, input logic [1:0] a, input logic [31:0] d);
        we = w; addr = a; din = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        we = 1'b0; din = $urandom;
        read_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd2, 32'd0);
    endtask

    // Asynchronous reset pulse taken between edges
    task automatic do_reset();
        we = 1'b0;
        reset = 1'b0;
        model_reset();
        read_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; addr = 2'd0; din = 32'd0;
        #2;
        do_reset();

        // Write on the very first edge after release is kept
        cycle(1'b1, 2'd1, 32'd5);
        chk_eq("first_wr", obs[1], 32'd5);

        // One-shot: PRESET=5, CTRL=0x9 at edge k
        cycle(1'b1, 2'd0, 32'h9);
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b0, 2'd0, 32'd0);
            if (i >= 2 && i <= 7) chk_eq("os_cnt", obs[2], 32'(7 - i));
            if (i <= 7) chk_eq("os_irq_lo", {31'd0, obs_irq}, 32'd0);
            if (i == 8) chk_eq("os_irq_hi", {31'd0, obs_irq}, 32'd1);
            if (i == 9) chk_eq("os_ctrl", obs[0], 32'h8);
        end
        idle(3);
        chk_eq("os_irq_hold", {31'd0, obs_irq}, 32'd1);
        cycle(1'b1, 2'd0, 32'h8);
        chk_eq("os_irq_ack", {31'd0, obs_irq}, 32'd0);

        // Auto-reload: PRESET=2, CTRL=0xB -> pulse every 5 cycles
        cycle(1'b1, 2'd1, 32'd2);
        cycle(1'b1, 2'd0, 32'hB);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 2'd0, 32'd0);
            chk_eq("ar_irq", {31'd0, obs_irq}, {31'd0, (i >= 5) && ((i - 5) % 5 == 0)});
            if (i % 5 == 2) chk_eq("ar_reload", obs[2], 32'd2);
        end
        cycle(1'b1, 2'd0, 32'h0);

        // Masked: CTRL=0x1, PRESET=1 -> irq never rises, EN still clears
        cycle(1'b1, 2'd0, 32'h1);
        cycle(1'b1, 2'd1, 32'd1);
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 2'd0, 32'd0);
            chk_eq("mask_irq", {31'd0, obs_irq}, 32'd0);
            if (i == 5) chk_eq("mask_en", obs[0], 32'h0);
        end

        // Disable in CNT at COUNT=3 holds COUNT
        cycle(1'b1, 2'd1, 32'd6);
        cycle(1'b1, 2'd0, 32'h1);
        idle(5);
        chk_eq("dis_pre", obs[2], 32'd3);
        cycle(1'b1, 2'd0, 32'h0);
        chk_eq("dis_hold", obs[2], 32'd3);
        idle(3);
        chk_eq("dis_idle", obs[2], 32'd3);

        // PRESET write in the INT cycle wins
        cycle(1'b1, 2'd1, 32'd0);
        cycle(1'b1, 2'd0, 32'h9);
        idle(3);
        chk_eq("pri_irq_int", {31'd0, obs_irq}, 32'd1);
        cycle(1'b1, 2'd1, 32'd4);
        chk_eq("pri_irq_clr", {31'd0, obs_irq}, 32'd0);
        idle(2);
        cycle(1'b1, 2'd0, 32'h0);

        // Reset mid-count at COUNT=7, then no writes
        cycle(1'b1, 2'd1, 32'd10);
        cycle(1'b1, 2'd0, 32'h1);
        idle(5);
        chk_eq("rst_pre", obs[2], 32'd7);
        do_reset();
        idle(4);
        chk_eq("rst_cnt", obs[2], 32'd0);

        // PRESET=0: irq three edges after the EN write; COUNT/addr3 writes ignored
        cycle(1'b1, 2'd0, 32'h9);
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 2'd0, 32'd0);
            chk_eq("p0_irq", {31'd0, obs_irq}, {31'd0, i == 3});
        end
        cycle(1'b1, 2'd2, 32'h55);
        chk_eq("cnt_ro", obs[2], 32'd0);
        cycle(1'b1, 2'd3, 32'hFFFF_FFFF);
        chk_eq("rsv_rd", obs[3], 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0]  a;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (r < 2) begin
                do_reset();
            end else if (r < 24) begin
                if (a == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
                if (a == 2'd1) d = 32'($urandom_range(0, 6));
                cycle(1'b1, a, d);
            end else begin
                cycle(1'b0, a, d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
